// File: rtl/alu_ctrl_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for alu_ctrl_seq: control-code width and encodings,
// ALUOp encodings, FSM state type and a helper that recognises the
// multiply/divide control codes.
// Optional feature macro used by the block: ALU_CTRL_SEQ_MEXT_EN.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    localparam int ALU_CTL_W = 4;
    typedef logic [ALU_CTL_W-1:0] alu_ctl_t;

    localparam alu_ctl_t CTL_ADD   = 4'b0000;
    localparam alu_ctl_t CTL_SHL   = 4'b0001;
    localparam alu_ctl_t CTL_SUB   = 4'b0010;
    localparam alu_ctl_t CTL_SLT   = 4'b0011;
    localparam alu_ctl_t CTL_XOR   = 4'b0100;
    localparam alu_ctl_t CTL_SRL   = 4'b0101;
    localparam alu_ctl_t CTL_OR    = 4'b0110;
    localparam alu_ctl_t CTL_AND   = 4'b0111;
    localparam alu_ctl_t CTL_MUL   = 4'b1000;
    localparam alu_ctl_t CTL_MULHU = 4'b1001;
    localparam alu_ctl_t CTL_DIVU  = 4'b1010;
    localparam alu_ctl_t CTL_REMU  = 4'b1011;
    localparam alu_ctl_t CTL_SLTU  = 4'b1100;
    localparam alu_ctl_t CTL_SRA   = 4'b1101;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_OTHER  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    // MUL/MULHU/DIVU/REMU occupy 10xx; their low two bits select the
    // muldiv_iter operation directly.
    function automatic logic is_muldiv(input alu_ctl_t ctl);
        return ctl[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq_if
// Request/response bundle of alu_ctrl_seq.
//   request : in_valid/in_ready, alu_op, funct3, op5, funct7_5, funct7_0,
//             src_a, src_b
//   response: out_valid/out_ready, result, zero, alu_ctl, busy
// master = control unit side, slave = alu_ctrl_seq side.
// ---------------------------------------------------------------------------
interface alu_ctrl_seq_if
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            op5;
    logic            funct7_5;
    logic            funct7_0;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    alu_ctl_t        alu_ctl;
    logic            busy;

    modport master (
        output in_valid, alu_op, funct3, op5, funct7_5, funct7_0, src_a, src_b,
               out_ready,
        input  in_ready, out_valid, result, zero, alu_ctl, busy
    );

    modport slave (
        input  in_valid, alu_op, funct3, op5, funct7_5, funct7_0, src_a, src_b,
               out_ready,
        output in_ready, out_valid, result, zero, alu_ctl, busy
    );

endinterface

// File: rtl/alu_ctrl_seq_muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter
// Iterative unsigned multiply (shift-add) / divide (restoring) core.
// Only compiled into alu_ctrl_seq when ALU_CTRL_SEQ_MEXT_EN is defined.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_start    load operands and begin (XLEN/ITER_PER_CYCLE clocks)
//   i_op       00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   i_a, i_b   multiplicand/multiplier or dividend/divisor
//   o_done     high in the clock whose edge performs the final step
//   o_result   value after the current clock's steps (valid with o_done)
// ---------------------------------------------------------------------------
module muldiv_iter #(
    parameter int XLEN           = 32,
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    localparam int STEPS = XLEN / ITER_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    // r_hi/r_lo: product {hi,lo} for multiply, {remainder,quotient} for divide
    logic [XLEN-1:0]  r_hi, r_lo, r_b;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic [XLEN-1:0]  w_hi, w_lo;
    logic [XLEN:0]    w_sum, w_rem;

    always_comb begin
        w_hi  = r_hi;
        w_lo  = r_lo;
        w_sum = '0;
        w_rem = '0;
        for (int unsigned i = 0; i < ITER_PER_CYCLE; i++) begin
            if (!r_op[1]) begin
                // add multiplicand into the high half, then shift the
                // 2*XLEN+1 bit accumulator right by one
                w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
                w_lo  = {w_sum[0], w_lo[XLEN-1:1]};
                w_hi  = w_sum[XLEN:1];
            end else begin
                w_rem = {w_hi, w_lo[XLEN-1]};
                w_lo  = {w_lo[XLEN-2:0], 1'b0};
                if (w_rem >= {1'b0, r_b}) begin
                    w_rem = w_rem - {1'b0, r_b};
                    w_lo[0] = 1'b1;
                end
                w_hi = w_rem[XLEN-1:0];
            end
        end
    end

    assign o_result = r_op[0] ? w_hi : w_lo;
    assign o_done   = r_busy && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_hi   <= '0;
            r_lo   <= i_a;
            r_b    <= i_b;
            r_op   <= i_op;
            r_cnt  <= CNT_LOAD;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_hi  <= w_hi;
            r_lo  <= w_lo;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
// ALU control decoder plus registered execution unit. Base ops complete in
// one clock; with ALU_CTRL_SEQ_MEXT_EN defined, MUL/MULHU/DIVU/REMU run on
// muldiv_iter (XLEN/ITER_PER_CYCLE clocks). Without the macro funct7_0 is
// ignored, the FSM uses only IDLE/DONE and busy is constant 0.
// Parameters: XLEN (power of 2, >= 8), ITER_PER_CYCLE (1, 2 or 4, divides XLEN)
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       alu_ctrl_seq_if.slave: request handshake + decode fields +
//             operands in, result handshake + result/zero/alu_ctl/busy out
// ---------------------------------------------------------------------------
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    alu_ctrl_seq_if.slave bus
);
    localparam int SH_W = $clog2(XLEN);

    state_t          r_state, w_next;
    logic [XLEN-1:0] r_result;
    alu_ctl_t        r_alu_ctl;

    alu_ctl_t        w_ctl;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_load_val;
    logic            w_load;
    logic [SH_W-1:0] w_shamt;

    assign w_shamt = bus.src_b[SH_W-1:0];

`ifdef ALU_CTRL_SEQ_MEXT_EN
    logic            w_start;
    logic            w_md_done;
    logic [XLEN-1:0] w_md_result;

    muldiv_iter #(
        .XLEN           (XLEN),
        .ITER_PER_CYCLE (ITER_PER_CYCLE)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_op     (w_ctl[1:0]),
        .i_a      (bus.src_a),
        .i_b      (bus.src_b),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );
`else
    logic w_unused_funct7_0;
    assign w_unused_funct7_0 = bus.funct7_0;
`endif

    // Decode
    always_comb begin
        w_ctl = CTL_ADD;
        case (bus.alu_op)
            ALUOP_BRANCH: begin
                case (bus.funct3[2:1])
                    2'b10:   w_ctl = CTL_SLT;
                    2'b11:   w_ctl = CTL_SLTU;
                    default: w_ctl = CTL_SUB;
                endcase
            end
            ALUOP_RTYPE: begin
`ifdef ALU_CTRL_SEQ_MEXT_EN
                if (bus.op5 && bus.funct7_0) begin
                    case (bus.funct3)
                        3'b000:  w_ctl = CTL_MUL;
                        3'b011:  w_ctl = CTL_MULHU;
                        3'b101:  w_ctl = CTL_DIVU;
                        3'b111:  w_ctl = CTL_REMU;
                        default: w_ctl = CTL_ADD;
                    endcase
                end else
`endif
                begin
                    case (bus.funct3)
                        3'b000:  w_ctl = (bus.op5 && bus.funct7_5) ? CTL_SUB : CTL_ADD;
                        3'b001:  w_ctl = CTL_SHL;
                        3'b010:  w_ctl = CTL_SLT;
                        3'b011:  w_ctl = CTL_SLTU;
                        3'b100:  w_ctl = CTL_XOR;
                        3'b101:  w_ctl = bus.funct7_5 ? CTL_SRA : CTL_SRL;
                        3'b110:  w_ctl = CTL_OR;
                        default: w_ctl = CTL_AND;
                    endcase
                end
            end
            default: w_ctl = CTL_ADD;
        endcase
    end

    // Single-cycle datapath
    always_comb begin
        w_base = '0;
        case (w_ctl)
            CTL_ADD:  w_base = bus.src_a + bus.src_b;
            CTL_SUB:  w_base = bus.src_a - bus.src_b;
            CTL_SHL:  w_base = bus.src_a << w_shamt;
            CTL_SRL:  w_base = bus.src_a >> w_shamt;
            CTL_SRA:  w_base = $unsigned($signed(bus.src_a) >>> w_shamt);
            CTL_SLT:  w_base = {{(XLEN-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
            CTL_SLTU: w_base = {{(XLEN-1){1'b0}}, bus.src_a < bus.src_b};
            CTL_XOR:  w_base = bus.src_a ^ bus.src_b;
            CTL_OR:   w_base = bus.src_a | bus.src_b;
            CTL_AND:  w_base = bus.src_a & bus.src_b;
`ifdef ALU_CTRL_SEQ_MEXT_EN
            // only selected for the divide-by-zero early-out
            CTL_DIVU: w_base = '1;
            CTL_REMU: w_base = bus.src_a;
`endif
            default:  w_base = '0;
        endcase
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_next        = r_state;
        w_load        = 1'b0;
        w_load_val    = w_base;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
`ifdef ALU_CTRL_SEQ_MEXT_EN
        w_start       = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
`ifdef ALU_CTRL_SEQ_MEXT_EN
                    if (is_muldiv(w_ctl) && !(w_ctl[1] && bus.src_b == '0)) begin
                        w_start = 1'b1;
                        w_next  = ST_EXEC;
                    end else
`endif
                    begin
                        w_load = 1'b1;
                        w_next = ST_DONE;
                    end
                end
            end
`ifdef ALU_CTRL_SEQ_MEXT_EN
            ST_EXEC: begin
                bus.busy = 1'b1;
                if (w_md_done) begin
                    w_load     = 1'b1;
                    w_load_val = w_md_result;
                    w_next     = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_result  <= '0;
            r_alu_ctl <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_result <= w_load_val;
            end
            if (r_state == ST_IDLE && bus.in_valid) begin
                r_alu_ctl <= w_ctl;
            end
        end
    end

    assign bus.result  = r_result;
    assign bus.zero    = (r_result == '0);
    assign bus.alu_ctl = r_alu_ctl;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_seq
// Self-checking bench for alu_ctrl_seq (XLEN=32, ITER_PER_CYCLE=1).
// Vector expectations follow the build: with ALU_CTRL_SEQ_MEXT_EN the
// M-group vectors expect multiply/divide results, otherwise the base-table
// fall-through results.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_seq;
    import alu_ctrl_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_ctrl_seq_if #(.XLEN(XLEN)) bus ();

    alu_ctrl_seq #(
        .XLEN           (XLEN),
        .ITER_PER_CYCLE (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  aop;
        logic [2:0]  f3;
        logic        op5;
        logic        f75;
        logic        f70;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  ctl;
        int          lat;
        int          busyc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  ctl;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    function automatic void add(input logic [1:0] aop, input logic [2:0] f3,
                                input logic op5, input logic f75, input logic f70,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic [3:0] ctl,
                                input int lat, input int busyc);
        vec_t v;
        v.aop = aop; v.f3 = f3; v.op5 = op5; v.f75 = f75; v.f70 = f70;
        v.a = a; v.b = b; v.res = res; v.ctl = ctl; v.lat = lat; v.busyc = busyc;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one clock; the bench only calls this in IDLE.
    task automatic send(input vec_t v);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.alu_op   = v.aop;
        bus.funct3   = v.f3;
        bus.op5      = v.op5;
        bus.funct7_5 = v.f75;
        bus.funct7_0 = v.f70;
        bus.src_a    = v.a;
        bus.src_b    = v.b;
        check("accept_in_ready", bus.in_ready, 1'b1);
        tick();
        e.res = v.res;
        e.ctl = v.ctl;
        sb.push_back(e);
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat counts edges from acceptance.
    task automatic wait_out(output int lat, output int busyc, output bit ok);
        lat   = 1;
        busyc = 0;
        for (int n = 0; n < 200 && !bus.out_valid; n++) begin
            if (bus.busy) busyc++;
            tick();
            lat++;
        end
        ok = bus.out_valid;
        if (!ok) begin
            check("out_valid_timeout", 1'b0, 1'b1);
        end
    endtask

    task automatic compare_out(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 1'b1, 1'b0);
            return;
        end
        e = sb.pop_front();
        check({name, "_result"}, bus.result, e.res);
        check({name, "_ctl"}, bus.alu_ctl, e.ctl);
        check({name, "_zero"}, bus.zero, (e.res == 32'd0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busyc, seen;
        bit ok;
        vec_t v;
        logic [31:0] held;

        bus.in_valid  = 1'b0;
        bus.alu_op    = '0;
        bus.funct3    = '0;
        bus.op5       = 1'b0;
        bus.funct7_5  = 1'b0;
        bus.funct7_0  = 1'b0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        tick();
        tick();
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result",    bus.result,    32'd0);
        check("rst_zero",      bus.zero,      1'b1);
        check("rst_alu_ctl",   bus.alu_ctl,   4'b0000);
        check("rst_busy",      bus.busy,      1'b0);
        rst = 1'b0;
        tick();

        //  aop    f3     op5 f75 f70 a             b             result        ctl     lat busy
        add(2'b10, 3'b000, 1, 1, 0, 32'd10,       32'd3,        32'd7,        4'b0010, 1, 0);
        add(2'b10, 3'b101, 0, 1, 0, 32'h80000000, 32'd4,        32'hF8000000, 4'b1101, 1, 0);
        add(2'b01, 3'b110, 0, 0, 0, 32'd1,        32'hFFFFFFFF, 32'd1,        4'b1100, 1, 0);
        add(2'b00, 3'b111, 1, 1, 1, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b0000, 1, 0);
        add(2'b10, 3'b001, 0, 0, 0, 32'd1,        32'h25,       32'h20,       4'b0001, 1, 0);
        add(2'b10, 3'b010, 1, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd1,        4'b0011, 1, 0);
        add(2'b10, 3'b010, 0, 0, 0, 32'd5,        32'd3,        32'd0,        4'b0011, 1, 0);
        add(2'b10, 3'b100, 1, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0100, 1, 0);
        add(2'b10, 3'b101, 1, 0, 0, 32'h80000000, 32'd4,        32'h08000000, 4'b0101, 1, 0);
        add(2'b10, 3'b101, 1, 1, 0, 32'h7FFFFFF0, 32'd4,        32'h07FFFFFF, 4'b1101, 1, 0);
        add(2'b10, 3'b110, 1, 0, 0, 32'h0000F000, 32'h000000F0, 32'h0000F0F0, 4'b0110, 1, 0);
        add(2'b10, 3'b111, 1, 0, 0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 4'b0111, 1, 0);
        add(2'b10, 3'b000, 0, 1, 0, 32'd5,        32'd7,        32'd12,       4'b0000, 1, 0);
        add(2'b01, 3'b000, 0, 0, 0, 32'd5,        32'd5,        32'd0,        4'b0010, 1, 0);
        add(2'b01, 3'b011, 0, 0, 0, 32'd9,        32'd4,        32'd5,        4'b0010, 1, 0);
        add(2'b01, 3'b100, 0, 0, 0, 32'h80000000, 32'd0,        32'd1,        4'b0011, 1, 0);
        add(2'b11, 3'b000, 0, 0, 0, 32'd3,        32'd4,        32'd7,        4'b0000, 1, 0);
        add(2'b10, 3'b011, 1, 0, 0, 32'd2,        32'd1,        32'd0,        4'b1100, 1, 0);
        add(2'b10, 3'b000, 0, 0, 1, 32'd3,        32'd4,        32'd7,        4'b0000, 1, 0);
`ifdef ALU_CTRL_SEQ_MEXT_EN
        add(2'b10, 3'b011, 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1001, 33, 32);
        add(2'b10, 3'b000, 1, 0, 1, 32'h00012345, 32'h00000100, 32'h01234500, 4'b1000, 33, 32);
        add(2'b10, 3'b101, 1, 0, 1, 32'd25,       32'd0,        32'hFFFFFFFF, 4'b1010, 1, 0);
        add(2'b10, 3'b111, 1, 0, 1, 32'd25,       32'd0,        32'd25,       4'b1011, 1, 0);
        add(2'b10, 3'b101, 1, 0, 1, 32'd100,      32'd7,        32'd14,       4'b1010, 33, 32);
        add(2'b10, 3'b111, 1, 0, 1, 32'd100,      32'd7,        32'd2,        4'b1011, 33, 32);
        add(2'b10, 3'b001, 1, 0, 1, 32'd3,        32'd4,        32'd7,        4'b0000, 1, 0);
        add(2'b10, 3'b000, 1, 1, 1, 32'd7,        32'd6,        32'd42,       4'b1000, 33, 32);
`else
        add(2'b10, 3'b011, 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        4'b1100, 1, 0);
        add(2'b10, 3'b000, 1, 0, 1, 32'h00012345, 32'h00000100, 32'h00012445, 4'b0000, 1, 0);
        add(2'b10, 3'b101, 1, 0, 1, 32'd25,       32'd0,        32'd25,       4'b0101, 1, 0);
        add(2'b10, 3'b111, 1, 0, 1, 32'd25,       32'd0,        32'd0,        4'b0111, 1, 0);
        add(2'b10, 3'b101, 1, 0, 1, 32'd100,      32'd7,        32'd0,        4'b0101, 1, 0);
        add(2'b10, 3'b111, 1, 0, 1, 32'd100,      32'd7,        32'd4,        4'b0111, 1, 0);
        add(2'b10, 3'b001, 1, 0, 1, 32'd3,        32'd4,        32'd48,       4'b0001, 1, 0);
        add(2'b10, 3'b000, 1, 1, 1, 32'd7,        32'd6,        32'd1,        4'b0010, 1, 0);
`endif

        foreach (vecs[i]) begin
            send(vecs[i]);
            wait_out(lat, busyc, ok);
            if (ok) begin
                compare_out($sformatf("vec%0d", i));
                check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
                check($sformatf("vec%0d_busy_cycles", i), busyc, vecs[i].busyc);
                tick();
                check($sformatf("vec%0d_release", i), {bus.out_valid, bus.in_ready}, 2'b01);
            end
        end

        // Backpressure: result held, new requests ignored while in DONE.
        v.aop = 2'b10; v.f3 = 3'b100; v.op5 = 1'b1; v.f75 = 1'b0; v.f70 = 1'b0;
        v.a = 32'h12345678; v.b = 32'hFFFF0000; v.res = 32'hEDCB5678; v.ctl = 4'b0100;
        v.lat = 1; v.busyc = 0;
        bus.out_ready = 1'b0;
        send(v);
        wait_out(lat, busyc, ok);
        held = bus.result;
        bus.in_valid = 1'b1;
        bus.alu_op   = 2'b00;
        bus.src_a    = 32'd1;
        bus.src_b    = 32'd1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_result_stable", bus.result, held);
        end
        bus.in_valid  = 1'b0;
        compare_out("bp");
        bus.out_ready = 1'b1;
        tick();
        check("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
        tick();
        check("bp_ignored_req", bus.out_valid, 1'b0);

        // Reset abort: DIVU 100/7 started, rst at cycle 10, nothing emitted.
        v.aop = 2'b10; v.f3 = 3'b101; v.op5 = 1'b1; v.f75 = 1'b0; v.f70 = 1'b1;
        v.a = 32'd100; v.b = 32'd7; v.res = 32'd14; v.ctl = 4'b1010;
        bus.out_ready = 1'b0;
        send(v);
        for (int c = 0; c < 9; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_in_ready", bus.in_ready, 1'b1);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_result", bus.result, 32'd0);
        sb.delete();
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        check("abort_no_output", seen, 0);

        // Recovery after abort
        v.aop = 2'b00; v.f3 = 3'b000; v.op5 = 1'b0; v.f75 = 1'b0; v.f70 = 1'b0;
        v.a = 32'd40; v.b = 32'd2; v.res = 32'd42; v.ctl = 4'b0000;
        send(v);
        wait_out(lat, busyc, ok);
        if (ok) begin
            compare_out("recover");
            check("recover_latency", lat, 1);
        end
        tick();
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised successor of the combinational ALU control decoder.
- Decodes ALUOp/funct3/op5/funct7 into a 4-bit ALU control code and executes the operation on XLEN-bit operands behind valid/ready handshakes.
- Base ops take one registered cycle. Multiply/divide ops (RV32M subset) run on an iterative sequencer.
- Sits between the main control unit and the writeback/branch logic of the multi-cycle core.

Parameters:
- XLEN, 32, operand/result width; must be a power of 2, minimum 8.
- ITER_PER_CYCLE, 1, multiply/divide bit-steps per clock; must be 1, 2 or 4 and divide XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- alu_op  in  2  00 load/store/add, 01 branch, 10 R/I-type
- funct3  in  3  instruction funct3
- op5  in  1  opcode bit 5 (1 = R-type)
- funct7_5  in  1  funct7 bit 5
- funct7_0  in  1  funct7 bit 0 (M-extension select)
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- alu_ctl  out  4  decoded control code of the held result
- busy  out  1  multi-cycle operation in progress

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, result=0, zero=1, alu_ctl=0, busy=0. FSM goes to IDLE and the iteration counter is cleared.
- Control codes:
  - ADD 0000, SHL 0001, SUB 0010, SLT 0011, XOR 0100, SRL 0101, OR 0110, AND 0111.
  - MUL 1000, MULHU 1001, DIVU 1010, REMU 1011, SLTU 1100, SRA 1101.
- Decode, alu_op=00: ADD, regardless of the other inputs.
- Decode, alu_op=01, by funct3:
  - 000/001 → SUB
  - 100/101 → SLT
  - 110/111 → SLTU
  - 010/011 → SUB
- Decode, alu_op=10:
  - op5 & funct7_0 → M-group, by funct3: 000 MUL, 011 MULHU, 101 DIVU, 111 REMU, others ADD.
  - Otherwise, by funct3:
    - 000: SUB if op5 & funct7_5, else ADD.
    - 001 SHL; 010 SLT; 011 SLTU; 100 XOR; 110 OR; 111 AND.
    - 101: SRA if funct7_5, else SRL.
- Decode, alu_op=11: ADD.
- Arithmetic rules:
  - Shift amount is src_b[log2(XLEN)-1:0].
  - SLT is signed and SLTU unsigned; both produce 1 or 0 zero-extended.
  - ADD/SUB wrap modulo 2^XLEN.
  - MUL returns the low XLEN bits; MULHU returns the high XLEN bits of the unsigned 2·XLEN product.
- FSM states: IDLE, EXEC, DONE.
  - IDLE, in_valid accepted, base op: result registered next edge → DONE. Latency 1.
  - IDLE, in_valid accepted, M op: latch operands → EXEC, busy=1, counter=XLEN/ITER_PER_CYCLE.
  - EXEC: shift-add (mul) or restoring shift-subtract (div), ITER_PER_CYCLE steps per clock. At counter 0, write result → DONE. Latency XLEN/ITER_PER_CYCLE+1.
  - DONE: out_valid=1, result/zero/alu_ctl held stable. out_ready=1 → IDLE.
- Handshake:
  - in_ready=1 only in IDLE.
  - Handshake completes when valid and ready are both 1 on a rising edge.
  - Inputs are ignored when in_ready=0.
- Boundary conditions:
  - DIVU with src_b=0: early-out with latency 1; result = all ones.
  - REMU with src_b=0: early-out with latency 1; result = src_a.
  - No early-out for zero multiplicands.
  - rst during EXEC or DONE aborts the operation. The result is discarded, out_valid=0 on the next cycle, and no partial result is ever presented.
  - out_ready held 0 in DONE: holds indefinitely; in_ready stays 0.
  - busy=1 exactly while in EXEC.

Optional Feature:
- Macro: ALU_CTRL_SEQ_MEXT_EN.
- Defined: M-group decode, the EXEC state and the iterative datapath are present.
- Undefined: funct7_0 is ignored and decode falls through to the base table. The FSM has only IDLE/DONE, busy is tied to 0, and no multiply/divide logic is synthesised.

Decomposition:
- Package alu_ctrl_pkg:
  - ALU_CTL_W=4 and all control-code localparams.
  - ALUOP encodings.
  - FSM state typedef {IDLE, EXEC, DONE}.
- Sub-module muldiv_iter: iterative unsigned mul/div core with start/done and ITER_PER_CYCLE/XLEN parameters. Compiled only under the macro.
- Decode and base datapath stay in the top.

Test Plan:
- Base op: alu_op=10, funct3=000, op5=1, funct7_5=1, src_a=10, src_b=3 → one cycle later out_valid=1, result=7, alu_ctl=0010, zero=0.
- SRA: funct3=101, funct7_5=1, src_a=0x80000000, src_b=4 → result=0xF8000000, alu_ctl=1101.
- Branch compare: alu_op=01, funct3=110, src_a=1, src_b=0xFFFFFFFF → result=1 (SLTU).
- MULHU (XLEN=32, ITER=1): src_a=src_b=0xFFFFFFFF → busy=1 for 32 cycles; out_valid at cycle 33; result=0xFFFFFFFE.
- DIVU by zero: src_a=25, src_b=0 → result=0xFFFFFFFF after 1 cycle. REMU with the same operands → result=25.
- Backpressure and reset: hold out_ready=0 for 5 cycles → result stable, in_ready=0. Then start DIVU 100/7 and assert rst at cycle 10 → out_valid=0, in_ready=1 next cycle, no result emitted.
